// File: rtl/ram_arbiter_pkg.sv
// Shared memory definitions: RAM flag codes, arbiter widths and owner-state encoding.
package ram_arbiter_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WFLAG_W = 2;
  localparam int unsigned RFLAG_W = 3;
  localparam int unsigned CNT_W   = 4;

  localparam logic [WFLAG_W-1:0] WFLAG_NONE = 2'd0;
  localparam logic [WFLAG_W-1:0] WFLAG_WORD = 2'd3;
  localparam logic [RFLAG_W-1:0] RFLAG_NONE = 3'd0;
  localparam logic [RFLAG_W-1:0] RFLAG_WORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_ctl.sv
// Per-cycle CPU/DMA grant with a saturating DMA starvation counter and a debug owner FSM.
module arb_starve_ctl
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cpu_req_i,
  input  logic             dma_req_i,
  output logic             cpu_gnt_o,
  output logic             dma_gnt_o,
  output logic [CNT_W-1:0] starve_cnt_o,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  arb_state_e       state_q, state_d;
  logic             cpu_gnt, dma_gnt;

  // Grant, starvation counter next value and owner next state.
  always_comb begin
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    starve_d = starve_q;
    state_d  = ST_IDLE;
    if (!rst_i) begin
      dma_gnt = dma_req_i && (!cpu_req_i || (starve_q == LIMIT));
      cpu_gnt = cpu_req_i && !dma_gnt;
    end
    if (!dma_req_i || dma_gnt) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + CNT_W'(1);
    end
    if (dma_gnt) begin
      state_d = ST_DMA;
    end else if (cpu_gnt) begin
      state_d = ST_CPU;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
      state_q  <= ST_IDLE;
    end else begin
      starve_q <= starve_d;
      state_q  <= state_d;
    end
  end

  assign cpu_gnt_o    = cpu_gnt;
  assign dma_gnt_o    = dma_gnt;
  assign starve_cnt_o = starve_q;
  assign state_o      = state_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the CPU ME stage and a DMA/loader, with DMA read return and stall counting.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AW           = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [AW-1:0]      cpu_addr_i,
  input  logic [DATA_W-1:0]  cpu_wdata_i,
  input  logic [WFLAG_W-1:0] cpu_wflag_i,
  input  logic [RFLAG_W-1:0] cpu_rflag_i,
  output logic [DATA_W-1:0]  cpu_rdata_o,
  output logic               cpu_stall_o,
  input  logic               dma_req_i,
  input  logic               dma_we_i,
  input  logic [AW-1:0]      dma_addr_i,
  input  logic [DATA_W-1:0]  dma_wdata_i,
  output logic               dma_gnt_o,
  output logic               dma_rvalid_o,
  output logic [DATA_W-1:0]  dma_rdata_o,
  output logic [AW-1:0]      ram_addr_o,
  output logic [DATA_W-1:0]  ram_wdata_o,
  output logic [WFLAG_W-1:0] ram_wflag_o,
  output logic [RFLAG_W-1:0] ram_rflag_o,
  input  logic [DATA_W-1:0]  ram_rdata_i,
  output logic [DATA_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]   starve_cnt_o,
  output logic [1:0]         state_o
);

  logic              cpu_req, cpu_gnt, dma_gnt, cpu_stall;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] stall_q, stall_d;

  assign cpu_req = (cpu_wflag_i != WFLAG_NONE) || (cpu_rflag_i != RFLAG_NONE);

  arb_starve_ctl #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_ctl (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req),
    .dma_req_i    (dma_req_i),
    .cpu_gnt_o    (cpu_gnt),
    .dma_gnt_o    (dma_gnt),
    .starve_cnt_o (starve_cnt_o),
    .state_o      (state_o)
  );

  assign cpu_stall = cpu_req && dma_gnt;

  // RAM port mux; a denied CPU store never reaches the port.
  always_comb begin
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wflag_o = WFLAG_NONE;
    ram_rflag_o = RFLAG_NONE;
    cpu_rdata_o = '0;
    if (dma_gnt) begin
      ram_addr_o  = dma_addr_i;
      ram_wdata_o = dma_wdata_i;
      if (dma_we_i) begin
        ram_wflag_o = WFLAG_WORD;
      end else begin
        ram_rflag_o = RFLAG_WORD;
      end
    end else if (cpu_gnt) begin
      ram_addr_o  = cpu_addr_i;
      ram_wdata_o = cpu_wdata_i;
      ram_wflag_o = cpu_wflag_i;
      ram_rflag_o = cpu_rflag_i;
      cpu_rdata_o = ram_rdata_i;
    end
  end

  always_comb begin
    rvalid_d = dma_gnt && !dma_we_i;
    rdata_d  = rvalid_d ? ram_rdata_i : rdata_q;
    stall_d  = cpu_stall ? stall_q + DATA_W'(1) : stall_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      stall_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      stall_q  <= stall_d;
    end
  end

  // A read granted just before reset must not report valid during the reset cycle.
  assign dma_rvalid_o   = rvalid_q && !rst_i;
  assign dma_rdata_o    = rdata_q;
  assign cpu_stall_o    = cpu_stall;
  assign dma_gnt_o      = dma_gnt;
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then random traffic against a reference model and RAM.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned AW           = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]  cpu_wflag;
  logic [2:0]  cpu_rflag;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0]  ram_wflag;
  logic [2:0]  ram_rflag;
  logic [31:0] stall_cycles;
  logic [3:0]  starve_cnt;
  logic [1:0]  state;

  logic        mem_init;
  logic [31:0] mem [16];

  logic [31:0] mem_ref [16];
  logic [3:0]  m_starve;
  logic        m_rvalid;
  logic [31:0] m_rdata, m_stall;
  arb_state_e  m_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .AW           (AW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cpu_addr_i     (cpu_addr),
    .cpu_wdata_i    (cpu_wdata),
    .cpu_wflag_i    (cpu_wflag),
    .cpu_rflag_i    (cpu_rflag),
    .cpu_rdata_o    (cpu_rdata),
    .cpu_stall_o    (cpu_stall),
    .dma_req_i      (dma_req),
    .dma_we_i       (dma_we),
    .dma_addr_i     (dma_addr),
    .dma_wdata_i    (dma_wdata),
    .dma_gnt_o      (dma_gnt),
    .dma_rvalid_o   (dma_rvalid),
    .dma_rdata_o    (dma_rdata),
    .ram_addr_o     (ram_addr),
    .ram_wdata_o    (ram_wdata),
    .ram_wflag_o    (ram_wflag),
    .ram_rflag_o    (ram_rflag),
    .ram_rdata_i    (ram_rdata),
    .stall_cycles_o (stall_cycles),
    .starve_cnt_o   (starve_cnt),
    .state_o        (state)
  );

  // Word RAM with combinational read, 16 words.
  assign ram_rdata = mem[ram_addr[5:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (ram_wflag != 2'd0) begin
      mem[ram_addr[5:2]] <= ram_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] wf, input logic [2:0] rf,
                       input logic [31:0] ca, input logic [31:0] cw,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    rst = r; cpu_wflag = wf; cpu_rflag = rf; cpu_addr = ca; cpu_wdata = cw;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  // Checks every output against the model for the current cycle, then advances one clock.
  task automatic tick();
    logic creq, dg, cg, st;
    logic [31:0] e_wf, e_rf, e_addr, e_wdata, e_crd;
    int wi_c, wi_d;
    #1;
    wi_c = int'(cpu_addr[5:2]);
    wi_d = int'(dma_addr[5:2]);
    creq = (cpu_wflag != 2'd0) || (cpu_rflag != 3'd0);
    dg   = !rst && dma_req && (!creq || (m_starve == 4'(STARVE_LIMIT)));
    cg   = !rst && creq && !dg;
    st   = creq && dg;
    e_wf = 32'h0; e_rf = 32'h0; e_addr = 32'h0; e_wdata = 32'h0; e_crd = 32'h0;
    if (dg) begin
      e_addr = dma_addr; e_wdata = dma_wdata;
      if (dma_we) e_wf = 32'(WFLAG_WORD);
      else        e_rf = 32'(RFLAG_WORD);
    end else if (cg) begin
      e_addr = cpu_addr; e_wdata = cpu_wdata;
      e_wf = 32'(cpu_wflag); e_rf = 32'(cpu_rflag);
      e_crd = mem_ref[wi_c];
    end
    check("dma_gnt", 32'(dma_gnt), 32'(dg));
    check("cpu_stall", 32'(cpu_stall), 32'(st));
    check("ram_wflag", 32'(ram_wflag), e_wf);
    check("ram_rflag", 32'(ram_rflag), e_rf);
    check("ram_addr", ram_addr, e_addr);
    check("ram_wdata", ram_wdata, e_wdata);
    check("cpu_rdata", cpu_rdata, e_crd);
    check("dma_rvalid", 32'(dma_rvalid), 32'(m_rvalid && !rst));
    check("dma_rdata", dma_rdata, m_rdata);
    check("stall_cycles", stall_cycles, m_stall);
    check("starve_cnt", 32'(starve_cnt), 32'(m_starve));
    check("state", 32'(state), 32'(m_state));
    @(posedge clk);
    if (rst) begin
      m_starve = 4'd0; m_rvalid = 1'b0; m_rdata = 32'h0; m_stall = 32'h0; m_state = ST_IDLE;
    end else begin
      if (dma_req && !dg)
        m_starve = (m_starve == 4'(STARVE_LIMIT)) ? m_starve : m_starve + 4'd1;
      else
        m_starve = 4'd0;
      m_rvalid = dg && !dma_we;
      if (m_rvalid) m_rdata = mem_ref[wi_d];
      if (st) m_stall = m_stall + 32'd1;
      m_state = dg ? ST_DMA : (cg ? ST_CPU : ST_IDLE);
      if (dg && dma_we) mem_ref[wi_d] = dma_wdata;
      else if (cg && cpu_wflag != 2'd0) mem_ref[wi_c] = cpu_wdata;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_ref[i] = 32'h0;
    mem_init = 1'b1;
    drive(1'b1, WFLAG_WORD, 3'd0, 32'h8, 32'h5555, 1'b1, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    m_starve = 4'd0; m_rvalid = 1'b0; m_rdata = 32'h0; m_stall = 32'h0; m_state = ST_IDLE;

    // Reset with both requesters asking: nothing granted.
    tick();
    check("rst_stall_cycles", stall_cycles, 32'h0);
    check("rst_state", 32'(state), 32'(ST_IDLE));

    // Single-source CPU store then load.
    drive(1'b0, WFLAG_WORD, 3'd0, 32'h8, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 check("cpu_store_stall", 32'(cpu_stall), 32'h0);
    tick();
    drive(1'b0, 2'd0, RFLAG_WORD, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 check("cpu_load_data", cpu_rdata, 32'hDEADBEEF);
    tick();

    // Single-source DMA read.
    drive(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
    #1 check("dma_read_gnt", 32'(dma_gnt), 32'h1);
    tick();
    drive(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 check("dma_read_rvalid", 32'(dma_rvalid), 32'h1);
    check("dma_read_rdata", dma_rdata, 32'hDEADBEEF);
    tick();

    // Starvation: DMA wins the fifth contested cycle.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'd0, RFLAG_WORD, 32'h8, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
      #1 check("starve_gnt", 32'(dma_gnt), (i == 4) ? 32'h1 : 32'h0);
      check("starve_stall", 32'(cpu_stall), (i == 4) ? 32'h1 : 32'h0);
      tick();
    end
    check("starve_stall_cycles", stall_cycles, 32'h1);

    // Denied CPU store while DMA writes the same word.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, RFLAG_WORD, 32'h8, 32'h0, 1'b1, 1'b1, 32'h4, 32'h22);
      tick();
    end
    drive(1'b0, WFLAG_WORD, 3'd0, 32'h4, 32'h11, 1'b1, 1'b1, 32'h4, 32'h22);
    #1 check("denied_store_stall", 32'(cpu_stall), 32'h1);
    tick();
    check("denied_store_mem", mem[1], 32'h22);
    drive(1'b0, WFLAG_WORD, 3'd0, 32'h4, 32'h11, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("retried_store_mem", mem[1], 32'h11);

    // Reset the cycle after a DMA read grant.
    drive(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    tick();
    drive(1'b1, WFLAG_WORD, 3'd0, 32'h4, 32'h99, 1'b1, 1'b0, 32'h4, 32'h0);
    #1 check("rst_mid_rvalid", 32'(dma_rvalid), 32'h0);
    check("rst_mid_wflag", 32'(ram_wflag), 32'h0);
    tick();
    check("rst_mid_stall_cycles", stall_cycles, 32'h0);
    check("rst_mid_rdata", dma_rdata, 32'h0);
    check("rst_mid_starve", 32'(starve_cnt), 32'h0);
    check("rst_mid_mem", mem[1], 32'h11);

    // Idle for three cycles.
    drive(1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    check("idle_state", 32'(state), 32'(ST_IDLE));
    check("idle_starve", 32'(starve_cnt), 32'h0);
    check("idle_wflag", 32'(ram_wflag), 32'h0);
    check("idle_rflag", 32'(ram_rflag), 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] wf;
      logic [2:0] rf;
      int kind;
      kind = int'($urandom_range(0, 2));
      wf = (kind == 1) ? 2'($urandom_range(1, 3)) : 2'd0;
      rf = (kind == 2) ? 3'($urandom_range(1, 5)) : 3'd0;
      drive(($urandom_range(0, 39) == 0), wf, rf,
            {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom());
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
